// File: rtl/commit_trace_emitter_pkg.sv
// Shared types and helpers for the commit-trace emitter.
// Holds the packet word width, header flag positions, the buffered record layout,
// the serializer state enum, and the functions that derive packet words from a record.
package commit_trace_emitter_pkg;

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned REC_W    = 55;

    localparam int unsigned HALT_BIT = 15;
    localparam int unsigned REGW_BIT = 14;
    localparam int unsigned MEMR_BIT = 13;
    localparam int unsigned MEMW_BIT = 12;
    localparam int unsigned SEL_LSB  = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_REG,
        ST_ADDR,
        ST_DATA
    } state_t;

    // One captured commit event; mem_data already holds load or store data.
    typedef struct packed {
        logic              halt;
        logic              reg_wr;
        logic              mem_rd;
        logic              mem_wr;
        logic [SEL_W-1:0]  reg_sel;
        logic [WORD_W-1:0] reg_data;
        logic [WORD_W-1:0] mem_addr;
        logic [WORD_W-1:0] mem_data;
    } rec_t;

    // Word following state s within the packet of r; ST_IDLE means s is the last word.
    function automatic state_t pkt_next(state_t s, rec_t r);
        state_t n;
        n = ST_IDLE;
        case (s)
            ST_HDR: begin
                if (r.reg_wr)                n = ST_REG;
                else if (r.mem_rd | r.mem_wr) n = ST_ADDR;
            end
            ST_REG:  if (r.mem_rd | r.mem_wr) n = ST_ADDR;
            ST_ADDR: n = ST_DATA;
            default: n = ST_IDLE;
        endcase
        return n;
    endfunction

    function automatic logic pkt_last(state_t s, rec_t r);
        return pkt_next(s, r) == ST_IDLE;
    endfunction

    function automatic logic [WORD_W-1:0] pkt_word(state_t s, rec_t r);
        logic [WORD_W-1:0] w;
        w = '0;
        case (s)
            ST_HDR: begin
                w[HALT_BIT]                 = r.halt;
                w[REGW_BIT]                 = r.reg_wr;
                w[MEMR_BIT]                 = r.mem_rd;
                w[MEMW_BIT]                 = r.mem_wr;
                w[SEL_LSB +: SEL_W]         = r.reg_sel;
            end
            ST_REG:  w = r.reg_data;
            ST_ADDR: w = r.mem_addr;
            ST_DATA: w = r.mem_data;
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/commit_trace_emitter_if.sv
// Trace stream port: 16-bit packet words with valid/ready handshake and end-of-packet flag.
//   master : emitter side (drives tr_valid, tr_word, tr_last; samples tr_ready)
//   slave  : sink side
interface commit_trace_emitter_if;
    import commit_trace_emitter_pkg::*;

    logic              tr_valid;
    logic              tr_ready;
    logic [WORD_W-1:0] tr_word;
    logic              tr_last;

    modport master (output tr_valid, output tr_word, output tr_last, input tr_ready);
    modport slave  (input tr_valid, input tr_word, input tr_last, output tr_ready);
endinterface

// File: rtl/commit_trace_emitter_fifo.sv
// Synchronous record FIFO with registered full/empty flags and occupancy count.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
//   clk, rst      : clock, synchronous active-low reset
//   push, wdata   : write request and record
//   pop, rdata    : read request and head record (valid while !empty)
//   full, empty   : registered status
module commit_trace_emitter_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 55
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          do_push;
    logic          do_pop;

    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign count_nxt = count + CW'(do_push) - CW'(do_pop);
    assign rdata     = mem[rd_ptr];

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers and status; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end
endmodule

// File: rtl/commit_trace_emitter.sv
// Commit-trace producer: captures per-cycle commit events, buffers them as records,
// and serializes each into a 1-4 word packet on the trace stream.
//   clk, rst                         : clock, synchronous active-low reset
//   reg_wr, reg_sel, reg_data        : register-file write event
//   mem_rd, mem_wr, mem_addr,
//   mem_wdata, mem_rdata             : data-memory access event
//   halt                             : halt commit
//   tr (master)                      : packet word stream
//   overflow, drop_count             : sticky drop flag and dropped-record count
//   inst_count                       : retired instruction count
//   done                             : halt packet delivered (or halt dropped and drained)
module commit_trace_emitter
    import commit_trace_emitter_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_wr,
    input  logic [SEL_W-1:0]      reg_sel,
    input  logic [WORD_W-1:0]     reg_data,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [WORD_W-1:0]     mem_addr,
    input  logic [WORD_W-1:0]     mem_wdata,
    input  logic [WORD_W-1:0]     mem_rdata,
    input  logic                  halt,
    commit_trace_emitter_if.master tr,
    output logic                  overflow,
    output logic [CNT_W-1:0]      drop_count,
    output logic [CNT_W-1:0]      inst_count,
    output logic                  done
);
    state_t            state;
    state_t            adv;
    rec_t              cur;
    rec_t              in_rec;
    rec_t              fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              halted;
    logic              halt_dropped;
    logic              valid_q;
    logic              last_q;
    logic [WORD_W-1:0] word_q;
    logic              capture;
    logic              retire;
    logic              hs;
    logic              pop;
    logic              drop;

    assign tr.tr_valid = valid_q;
    assign tr.tr_word  = word_q;
    assign tr.tr_last  = last_q;

    // Record formation; a simultaneous load and store reports the load data.
    assign in_rec.halt     = halt;
    assign in_rec.reg_wr   = reg_wr;
    assign in_rec.mem_rd   = mem_rd;
    assign in_rec.mem_wr   = mem_wr;
    assign in_rec.reg_sel  = reg_sel;
    assign in_rec.reg_data = reg_data;
    assign in_rec.mem_addr = mem_addr;
    assign in_rec.mem_data = mem_rd ? mem_rdata : mem_wdata;

    assign capture = (reg_wr | mem_rd | mem_wr | halt) & ~halted;
    assign retire  = capture & (halt | reg_wr | mem_wr);
    assign hs      = valid_q & tr.tr_ready;
    // Load a new packet when idle or as the current one finishes, so packets abut.
    assign pop     = ~fifo_empty & ((state == ST_IDLE) | (hs & last_q));
    assign drop    = capture & fifo_full & ~pop;
    assign adv     = pkt_next(state, cur);

    commit_trace_emitter_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .wdata (in_rec),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Counters, sticky flags and halt tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inst_count   <= '0;
            drop_count   <= '0;
            overflow     <= 1'b0;
            halted       <= 1'b0;
            halt_dropped <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (retire && (inst_count != '1)) inst_count <= inst_count + CNT_W'(1);
            if (drop) begin
                if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
                overflow <= 1'b1;
                if (halt) halt_dropped <= 1'b1;
            end
            if (capture && halt) halted <= 1'b1;
            if ((hs && last_q && cur.halt) ||
                (halt_dropped && fifo_empty && (state == ST_IDLE)))
                done <= 1'b1;
        end
    end

    // Serializer: outputs are registered alongside the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cur     <= '0;
            valid_q <= 1'b0;
            word_q  <= '0;
            last_q  <= 1'b0;
        end else if (pop) begin
            state   <= ST_HDR;
            cur     <= fifo_rdata;
            valid_q <= 1'b1;
            word_q  <= pkt_word(ST_HDR, fifo_rdata);
            last_q  <= pkt_last(ST_HDR, fifo_rdata);
        end else if (hs) begin
            if (last_q) begin
                state   <= ST_IDLE;
                valid_q <= 1'b0;
                word_q  <= '0;
                last_q  <= 1'b0;
            end else begin
                state  <= adv;
                word_q <= pkt_word(adv, cur);
                last_q <= pkt_last(adv, cur);
            end
        end
    end
endmodule

// File: tb/tb_commit_trace_emitter.sv
// Self-checking bench for commit_trace_emitter: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// queue-based packet model.
module tb_commit_trace_emitter;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic        halt;
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
        logic [2:0]  reg_sel;
        logic [15:0] reg_data;
        logic [15:0] mem_addr;
        logic [15:0] mem_wdata;
        logic [15:0] mem_rdata;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    ev_t         in_ev;
    logic        overflow;
    logic        done;
    logic [31:0] drop_count;
    logic [31:0] inst_count;

    commit_trace_emitter_if tr();

    commit_trace_emitter #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .reg_wr     (in_ev.reg_wr),
        .reg_sel    (in_ev.reg_sel),
        .reg_data   (in_ev.reg_data),
        .mem_rd     (in_ev.mem_rd),
        .mem_wr     (in_ev.mem_wr),
        .mem_addr   (in_ev.mem_addr),
        .mem_wdata  (in_ev.mem_wdata),
        .mem_rdata  (in_ev.mem_rdata),
        .halt       (in_ev.halt),
        .tr         (tr),
        .overflow   (overflow),
        .drop_count (drop_count),
        .inst_count (inst_count),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Model state: packet words in flight ({last, word}) and buffered events.
    logic [16:0] m_cur[$];
    ev_t         m_fifo[$];
    bit          m_cur_halt;
    logic [31:0] m_inst;
    logic [31:0] m_drop;
    bit          m_ovf, m_done, m_halted, m_hdrop;
    bit          m_hs, m_lhs, m_pop, m_cap, m_acc, m_dset;
    ev_t         m_e;

    logic [16:0] obs_log[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          chk_en   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic load_pkt(input ev_t e);
        bit mem;
        mem = e.mem_rd | e.mem_wr;
        m_cur.delete();
        m_cur_halt = e.halt;
        m_cur.push_back({!e.reg_wr && !mem, e.halt, e.reg_wr, e.mem_rd, e.mem_wr, e.reg_sel, 9'b0});
        if (e.reg_wr) m_cur.push_back({!mem, e.reg_data});
        if (mem) begin
            m_cur.push_back({1'b0, e.mem_addr});
            m_cur.push_back({1'b1, e.mem_rd ? e.mem_rdata : e.mem_wdata});
        end
    endtask

    // Reference model, advanced at each active edge from the values the DUT samples.
    always @(posedge clk) begin
        if (!rst) begin
            m_cur.delete(); m_fifo.delete();
            m_cur_halt = 0; m_inst = 0; m_drop = 0;
            m_ovf = 0; m_done = 0; m_halted = 0; m_hdrop = 0;
        end else begin
            m_hs   = (m_cur.size() != 0) && (tr.tr_ready === 1'b1);
            m_lhs  = m_hs && (m_cur.size() == 1);
            m_pop  = (m_fifo.size() != 0) && ((m_cur.size() == 0) || m_lhs);
            m_cap  = !m_halted && (in_ev.halt | in_ev.reg_wr | in_ev.mem_rd | in_ev.mem_wr);
            m_dset = (m_lhs && m_cur_halt) || (m_hdrop && m_fifo.size() == 0 && m_cur.size() == 0);
            m_acc  = 0;
            if (m_cap) begin
                if ((in_ev.halt | in_ev.reg_wr | in_ev.mem_wr) && m_inst != 32'hFFFF_FFFF) m_inst++;
                if (in_ev.halt) m_halted = 1;
                if (m_fifo.size() == DEPTH && !m_pop) begin
                    if (m_drop != 32'hFFFF_FFFF) m_drop++;
                    m_ovf = 1;
                    if (in_ev.halt) m_hdrop = 1;
                end else m_acc = 1;
            end
            if (m_hs) void'(m_cur.pop_front());
            if (m_pop) begin
                m_e = m_fifo.pop_front();
                load_pkt(m_e);
            end
            if (m_acc) m_fifo.push_back(in_ev);
            if (m_dset) m_done = 1;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("tr_valid", 32'(tr.tr_valid), 32'(m_cur.size() != 0));
            if (m_cur.size() != 0) begin
                check("tr_word", 32'(tr.tr_word), 32'(m_cur[0][15:0]));
                check("tr_last", 32'(tr.tr_last), 32'(m_cur[0][16]));
            end
            check("overflow",   32'(overflow), 32'(m_ovf));
            check("drop_count", drop_count,    m_drop);
            check("inst_count", inst_count,    m_inst);
            check("done",       32'(done),     32'(m_done));
            if (rst && tr.tr_valid && tr.tr_ready) obs_log.push_back({tr.tr_last, tr.tr_word});
        end
    end

    function automatic ev_t mk(input logic h, rw, mr, mw, input logic [2:0] sel,
                               input logic [15:0] rd, ad, wd, rdt);
        ev_t e;
        e.halt = h; e.reg_wr = rw; e.mem_rd = mr; e.mem_wr = mw; e.reg_sel = sel;
        e.reg_data = rd; e.mem_addr = ad; e.mem_wdata = wd; e.mem_rdata = rdt;
        return e;
    endfunction

    task automatic cyc(input ev_t e);
        in_ev = e;
        @(posedge clk); #1;
        in_ev = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b0; in_ev = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk_en = 1'b1;
        obs_log.delete();
    endtask

    task automatic check_log(input string nm, input int n, input logic [16:0] e0, e1, e2, e3);
        logic [16:0] e[4];
        e = '{e0, e1, e2, e3};
        check({nm, "_len"}, 32'(obs_log.size()), 32'(n));
        for (int i = 0; i < n; i++) check(nm, 32'(obs_log[i]), 32'(e[i]));
        obs_log.delete();
    endtask

    initial begin
        rst = 1'b1; in_ev = '0; tr.tr_ready = 1'b0;
        do_reset();
        check("rst_valid", 32'(tr.tr_valid), 32'd0);
        check("rst_inst",  inst_count, 32'd0);
        check("rst_done",  32'(done), 32'd0);

        // 1: single register write
        tr.tr_ready = 1'b1;
        cyc(mk(0, 1, 0, 0, 3'd3, 16'h1234, 16'h0, 16'h0, 16'h0));
        idle(6);
        check_log("t1", 2, 17'h04600, 17'h11234, 17'h0, 17'h0);
        check("t1_inst", inst_count, 32'd1);

        // 2: store
        cyc(mk(0, 0, 0, 1, 3'd0, 16'h0, 16'h0010, 16'hBEEF, 16'h0));
        idle(6);
        check_log("t2", 3, 17'h01000, 17'h00010, 17'h1BEEF, 17'h0);

        // 3: load plus register write, four-word packet
        cyc(mk(0, 1, 1, 0, 3'd7, 16'hAAAA, 16'h0020, 16'h0, 16'h5555));
        idle(8);
        check_log("t3", 4, 17'h06E00, 17'h0AAAA, 17'h00020, 17'h15555);
        check("t3_inst", inst_count, 32'd3);

        // 4: overflow with a stalled sink, then drain
        tr.tr_ready = 1'b0;
        for (int i = 0; i < 10; i++)
            cyc(mk(0, 1, 0, 0, 3'(i), 16'(16'h0100 + i), 16'h0, 16'h0, 16'h0));
        idle(2);
        check("t4_drop", drop_count, 32'd1);
        check("t4_ovf",  32'(overflow), 32'd1);
        check("t4_inst", inst_count, 32'd13);
        tr.tr_ready = 1'b1;
        idle(25);
        check("t4_words", 32'(obs_log.size()), 32'd18);
        check("t4_first", 32'(obs_log[0]), 32'h04000);
        check("t4_second", 32'(obs_log[1]), 32'h10100);
        check("t4_tail", 32'(obs_log[17]), 32'h10108);
        obs_log.delete();

        // 5: halt with register write; subsequent events ignored
        do_reset();
        tr.tr_ready = 1'b1;
        cyc(mk(1, 1, 0, 0, 3'd1, 16'h0001, 16'h0, 16'h0, 16'h0));
        cyc(mk(0, 1, 0, 0, 3'd5, 16'h9999, 16'h0, 16'h0, 16'h0));
        idle(6);
        check_log("t5", 2, 17'h0C200, 17'h10001, 17'h0, 17'h0);
        check("t5_inst", inst_count, 32'd1);
        check("t5_done", 32'(done), 32'd1);

        // 6: reset in the middle of a packet
        do_reset();
        tr.tr_ready = 1'b1;
        cyc(mk(0, 1, 1, 0, 3'd7, 16'hAAAA, 16'h0020, 16'h0, 16'h5555));
        for (int i = 0; i < 20 && !(tr.tr_valid === 1'b1 && tr.tr_word === 16'hAAAA); i++) idle(1);
        check("t6_reach", 32'(tr.tr_word), 32'h0000AAAA);
        rst = 1'b0;
        idle(1);
        check("t6_valid", 32'(tr.tr_valid), 32'd0);
        check("t6_inst",  inst_count, 32'd0);
        rst = 1'b1;
        obs_log.delete();
        cyc(mk(0, 1, 0, 0, 3'd2, 16'h00FF, 16'h0, 16'h0, 16'h0));
        idle(5);
        check_log("t6", 2, 17'h04400, 17'h100FF, 17'h0, 17'h0);

        // 7: halt record dropped on a full FIFO; done after drain
        do_reset();
        tr.tr_ready = 1'b0;
        for (int i = 0; i < 10; i++)
            cyc(mk(0, 1, 0, 0, 3'(i), 16'(i), 16'h0, 16'h0, 16'h0));
        cyc(mk(1, 0, 0, 0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0));
        idle(1);
        check("t7_drop", drop_count, 32'd2);
        check("t7_notdone", 32'(done), 32'd0);
        tr.tr_ready = 1'b1;
        idle(30);
        check("t7_done", 32'(done), 32'd1);
        check("t7_inst", inst_count, 32'd11);

        // Randomized traffic with alternating stalled and flowing sink
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            ev_t e;
            e = '0;
            if ($urandom_range(0, 9) < 6) begin
                e.reg_wr    = 1'($urandom_range(0, 1));
                e.mem_rd    = 1'($urandom_range(0, 1));
                e.mem_wr    = 1'($urandom_range(0, 1));
                e.reg_sel   = 3'($urandom);
                e.reg_data  = 16'($urandom);
                e.mem_addr  = 16'($urandom);
                e.mem_wdata = 16'($urandom);
                e.mem_rdata = 16'($urandom);
            end
            tr.tr_ready = ((c % 500) < 120) ? ($urandom_range(0, 9) == 0)
                                           : ($urandom_range(0, 9) < 8);
            cyc(e);
        end
        tr.tr_ready = 1'b1;
        cyc(mk(1, 0, 1, 0, 3'd4, 16'h0, 16'h1111, 16'h0, 16'h2222));
        idle(200);
        check("rand_done", 32'(done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
